cordic_rr_arbiter: RTL and testbench

Round-robin scheduler that shares one fixed-latency CORDIC magnitude/phase pipeline between NUM_CH independent AXI-Stream requesters. It sits in front of the CORDIC and tags each issued sample with its channel, then steers each result into that channel's result FIFO. Issue is credit-based, so results always have space and the CORDIC never stalls.

---
 rtl/cordic_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_cordic_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_arbiter.sv
// cordic_rr_arbiter: shares one fixed-latency CORDIC pipeline between NUM_CH AXI-Stream
// requesters. Round-robin, credit-based issue; results return via per-channel FWFT FIFOs.
// Optional packet lock: define CORDIC_ARB_PKT_LOCK_EN to hold the grant until tlast.
module cordic_rr_arbiter #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LATENCY    = 17,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic                         s00_axis_aclk,
   input  logic                         s00_axis_aresetn,
   input  logic [NUM_CH-1:0]            s_axis_tvalid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]            s_axis_tlast,
   output logic [NUM_CH-1:0]            s_axis_tready,
   output logic                         cordic_tvalid,
   output logic [DATA_WIDTH-1:0]        cordic_tdata,
   output logic                         cordic_tlast,
   output logic                         cordic_tready,
   input  logic                         cordic_res_tvalid,
   input  logic [DATA_WIDTH-1:0]        cordic_res_tdata,
   input  logic                         cordic_res_tlast,
   output logic [NUM_CH-1:0]            m_axis_tvalid,
   output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [NUM_CH-1:0]            m_axis_tlast,
   input  logic [NUM_CH-1:0]            m_axis_tready,
   output logic                         err
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = DATA_WIDTH + 1;

   logic [CW-1:0]         credit_q [NUM_CH];
   logic [CW-1:0]         credit_d [NUM_CH];
   logic [PW-1:0]         ptr_q;
   logic [NUM_CH-1:0]     eligible, grant, pop, fifo_wr;
   logic                  issue;
   logic [PW-1:0]         gnt_id;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  gnt_last;

   logic                  cordic_tvalid_q, cordic_tlast_q, err_q;
   logic [DATA_WIDTH-1:0] cordic_tdata_q;
   logic [PW-1:0]         cordic_ch_q;

   logic [LATENCY-1:0]    tag_v_q;
   logic [PW-1:0]         tag_id_q [LATENCY];
   logic                  tag_v;
   logic [PW-1:0]         tag_id;

   logic [EW-1:0]         mem_q [NUM_CH][FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q [NUM_CH];
   logic [AW:0]           rd_ptr_q [NUM_CH];

`ifdef CORDIC_ARB_PKT_LOCK_EN
   logic                  lock_q;
   logic [PW-1:0]         lock_ch_q;

   // Packet lock: a non-last beat pins the grant to its channel until that channel's tlast issues
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
      end else if (issue) begin
         lock_q    <= !gnt_last;
         lock_ch_q <= gnt_id;
      end
   end
`endif

   // Eligibility: valid request with at least one free result slot
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         eligible[c] = s_axis_tvalid[c] && (credit_q[c] != '0);
`ifdef CORDIC_ARB_PKT_LOCK_EN
         if (lock_q && (lock_ch_q != PW'(c))) eligible[c] = 1'b0;
`endif
      end
   end

   // Round-robin search starting just after the last granted channel
   always_comb begin
      logic [PW:0] idx;
      idx      = '0;
      issue    = 1'b0;
      gnt_id   = ptr_q;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = {1'b0, ptr_q} + (PW+1)'(i);
         if (idx >= (PW+1)'(NUM_CH)) idx = idx - (PW+1)'(NUM_CH);
         if (!issue && eligible[idx[PW-1:0]]) begin
            issue  = 1'b1;
            gnt_id = idx[PW-1:0];
         end
      end
      // No handshake may complete while reset is held
      if (!s00_axis_aresetn) issue = 1'b0;
      gnt_data = '0;
      gnt_last = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         grant[c] = issue && (gnt_id == PW'(c));
         if (grant[c]) begin
            gnt_data = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
            gnt_last = s_axis_tlast[c];
         end
      end
   end

   assign s_axis_tready = grant;

   // Credit next-state: issue consumes a slot, downstream pop returns one
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         pop[c]      = m_axis_tvalid[c] && m_axis_tready[c];
         credit_d[c] = credit_q[c];
         if (grant[c] && !pop[c]) credit_d[c] = credit_q[c] - CW'(1);
         else if (pop[c] && !grant[c]) credit_d[c] = credit_q[c] + CW'(1);
      end
   end

   // Issue register toward the CORDIC, pointer and credit state
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         cordic_tvalid_q <= 1'b0;
         cordic_tdata_q  <= '0;
         cordic_tlast_q  <= 1'b0;
         cordic_ch_q     <= '0;
         ptr_q           <= PW'(NUM_CH - 1);
         for (int c = 0; c < NUM_CH; c++) credit_q[c] <= CW'(FIFO_DEPTH);
      end else begin
         cordic_tvalid_q <= issue;
         if (issue) begin
            cordic_tdata_q <= gnt_data;
            cordic_tlast_q <= gnt_last;
            cordic_ch_q    <= gnt_id;
            ptr_q          <= gnt_id;
         end
         for (int c = 0; c < NUM_CH; c++) credit_q[c] <= credit_d[c];
      end
   end

   assign cordic_tvalid = cordic_tvalid_q;
   assign cordic_tdata  = cordic_tdata_q;
   assign cordic_tlast  = cordic_tlast_q;
   assign cordic_tready = 1'b1;

   // Tag pipeline: mirrors CORDIC latency so the channel id lines up with the result
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         tag_v_q <= '0;
         for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         tag_v_q[0]  <= cordic_tvalid_q;
         tag_id_q[0] <= cordic_ch_q;
         for (int i = 1; i < LATENCY; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
         if (tag_v != cordic_res_tvalid) err_q <= 1'b1;
      end
   end

   assign tag_v  = tag_v_q[LATENCY-1];
   assign tag_id = tag_id_q[LATENCY-1];
   assign err    = err_q;

   // Result steering: only write when tag and CORDIC agree a result is present
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         fifo_wr[c] = tag_v && cordic_res_tvalid && (tag_id == PW'(c));
      end
   end

   // FIFO storage, no reset needed: contents are only observed through the pointers
   always_ff @(posedge s00_axis_aclk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (fifo_wr[c]) mem_q[c][wr_ptr_q[c][AW-1:0]] <= {cordic_res_tdata, cordic_res_tlast};
      end
   end

   // FIFO pointers, one extra bit distinguishes full from empty
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (fifo_wr[c]) wr_ptr_q[c] <= wr_ptr_q[c] + (AW+1)'(1);
            if (pop[c])     rd_ptr_q[c] <= rd_ptr_q[c] + (AW+1)'(1);
         end
      end
   end

   // First-word fall-through outputs, zeroed while empty
   always_comb begin
      logic [EW-1:0] head;
      head = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_axis_tvalid[c] = (wr_ptr_q[c] != rd_ptr_q[c]);
         head             = m_axis_tvalid[c] ? mem_q[c][rd_ptr_q[c][AW-1:0]] : '0;
         m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = head[EW-1:1];
         m_axis_tlast[c]  = head[0];
      end
   end

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// tb_cordic_rr_arbiter: scoreboard bench with a behavioural CORDIC stand-in and an
// arbitration/credit reference model. Packet-lock checks follow CORDIC_ARB_PKT_LOCK_EN.
module tb_cordic_rr_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 64;
   localparam int HW  = DW / 2;
   localparam int LAT = 17;
   localparam int FD  = 32;
   localparam int SB  = 1024;
`ifdef CORDIC_ARB_PKT_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
   logic [NCH*DW-1:0] s_tdata, m_tdata;
   logic              c_tvalid, c_tlast, c_tready, r_tvalid, r_tlast, err, inj;
   logic [DW-1:0]     c_tdata, r_tdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   cordic_rr_arbiter #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(FD)
   ) dut (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .cordic_tvalid(c_tvalid), .cordic_tdata(c_tdata), .cordic_tlast(c_tlast),
      .cordic_tready(c_tready),
      .cordic_res_tvalid(r_tvalid), .cordic_res_tdata(r_tdata), .cordic_res_tlast(r_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Stand-in CORDIC: mag = isqrt(I^2+Q^2) on the low 16 bits (plus a fold of upper bits),
   // angle = I xor Q. Only needs to be deterministic; the arbiter passes results through.
   function automatic logic [DW-1:0] cordic_fn(input logic [DW-1:0] d);
      logic [HW-1:0]   iv, qv, mag;
      longint unsigned s, r, t;
      iv = d[HW-1:0];
      qv = d[DW-1:HW];
      s  = 64'(iv[15:0]) * 64'(iv[15:0]) + 64'(qv[15:0]) * 64'(qv[15:0]);
      r  = 0;
      for (int b = 17; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= s) r = t;
      end
      mag = HW'(r) + {iv[HW-1:16] ^ qv[HW-1:16], 16'h0};
      return {iv ^ qv, mag};
   endfunction

   // CORDIC pipeline model, sharing the arbiter reset
   logic          pv [LAT];
   logic [DW-1:0] pd [LAT];
   logic          pl [LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            pv[i] <= 1'b0; pd[i] <= '0; pl[i] <= 1'b0;
         end
      end else begin
         pv[0] <= c_tvalid; pd[0] <= cordic_fn(c_tdata); pl[0] <= c_tlast;
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; pl[i] <= pl[i-1];
         end
      end
   end
   assign r_tvalid = pv[LAT-1] | inj;
   assign r_tdata  = pd[LAT-1];
   assign r_tlast  = pl[LAT-1];

   // Scoreboard storage: written by the model, read by the monitor
   logic [DW:0]   exp_ent [NCH][SB];
   int            exp_due [NCH][SB];
   int            wr_idx [NCH];
   int            rd_idx [NCH];
   int            mptr = NCH - 1;
   bit            mlock = 1'b0;
   int            mlock_ch = 0;
   bit            exp_err = 1'b0;
   bit            prev_issue = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         wr_idx[c] = 0;
         rd_idx[c] = 0;
      end
   end

   // Reference model: predicts grant from credits (slots not yet popped) and RR order
   always @(negedge clk) begin
      logic [NCH-1:0] exp_rdy;
      int             g, c;
      exp_rdy = '0;
      g       = -1;
      if (!rst_n) begin
         mptr = NCH - 1; mlock = 1'b0; exp_err = 1'b0; prev_issue = 1'b0;
         check("rst_s_tready", s_tready, 0);
         check("rst_cordic_tvalid", c_tvalid, 0);
         check("rst_cordic_tdata", c_tdata, 0);
         check("rst_cordic_tlast", c_tlast, 0);
         check("rst_cordic_tready", c_tready, 1);
         check("rst_err", err, 0);
      end else begin
         for (int k = 1; k <= NCH && g < 0; k++) begin
            c = (mptr + k) % NCH;
            if (s_tvalid[c] && (FD - (wr_idx[c] - rd_idx[c])) > 0 && (!mlock || c == mlock_ch))
               g = c;
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("s_tready", s_tready, exp_rdy);
         check("cordic_tvalid", c_tvalid, prev_issue);
         if (prev_issue) begin
            check("cordic_tdata", c_tdata, prev_data);
            check("cordic_tlast", c_tlast, prev_last);
         end
         check("cordic_tready", c_tready, 1);
         check("err", err, exp_err);
         prev_issue = (g >= 0);
         if (g >= 0) begin
            prev_data = s_tdata[g*DW +: DW];
            prev_last = s_tlast[g];
            exp_ent[g][wr_idx[g] % SB] = {cordic_fn(prev_data), prev_last};
            exp_due[g][wr_idx[g] % SB] = cyc + LAT + 2;
            wr_idx[g]++;
            mptr     = g;
            mlock    = LockEn && !prev_last;
            mlock_ch = g;
         end
         // Injected result with no tag in flight
         if (inj) exp_err = 1'b1;
      end
   end

   // Monitor: results become visible at their due cycle, in issue order per channel
   always @(negedge clk) begin
      bit ev;
      #1;
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            rd_idx[c] = wr_idx[c];
            check($sformatf("rst_m_tvalid[%0d]", c), m_tvalid[c], 0);
            check($sformatf("rst_m_tdata[%0d]", c), {m_tdata[c*DW +: DW], m_tlast[c]}, 0);
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            ev = (rd_idx[c] < wr_idx[c]) && (exp_due[c][rd_idx[c] % SB] <= cyc);
            check($sformatf("m_tvalid[%0d]", c), m_tvalid[c], ev);
            if (ev && m_tvalid[c]) begin
               check($sformatf("m_tdata[%0d]", c), {m_tdata[c*DW +: DW], m_tlast[c]},
                     exp_ent[c][rd_idx[c] % SB]);
               if (m_tready[c]) rd_idx[c]++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beats();
      for (int c = 0; c < NCH; c++) begin
         s_tdata[c*DW +: DW] = {$urandom, $urandom};
         s_tlast[c]          = 1'($urandom);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (got running, required done)");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int w;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = '1; inj = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // Single channel 0, five back-to-back beats
      for (int b = 0; b < 5; b++) begin
         s_tvalid = 4'b0001;
         s_tdata[0 +: DW] = {$urandom, $urandom};
         s_tlast[0] = (b == 4);
         step();
      end
      s_tvalid = '0;
      repeat (25) step();

      // All channels continuously valid
      s_tvalid = '1;
      repeat (40) begin rand_beats(); step(); end
      s_tvalid = '0;
      repeat (25) step();

      // Channel 1 stalled downstream: credits run out, others keep flowing
      m_tready = 4'b1101;
      s_tvalid = '1;
      repeat (160) begin rand_beats(); step(); end
      check("ch1_blocked", s_tready[1], 0);
      m_tready = '1;
      repeat (80) begin rand_beats(); step(); end
      s_tvalid = '0;
      repeat (25) step();

      // I=3, Q=4 on channel 2 gives magnitude 5
      s_tvalid = 4'b0100;
      s_tdata[2*DW +: DW] = {32'd4, 32'd3};
      s_tlast[2] = 1'b1;
      step();
      s_tvalid = '0;
      w = 0;
      while (!m_tvalid[2] && w < 40) begin step(); w++; end
      check("mag_latency", w, LAT + 1);
      check("mag_field", m_tdata[2*DW +: HW], 5);
      check("mag_err", err, 0);
      repeat (5) step();

      // Random traffic with random downstream back-pressure
      repeat (400) begin
         s_tvalid = 4'($urandom);
         for (int c = 0; c < NCH; c++) m_tready[c] = ($urandom_range(3, 0) != 0);
         rand_beats();
         step();
      end
      s_tvalid = '0; m_tready = '1;
      repeat (60) step();

`ifdef CORDIC_ARB_PKT_LOCK_EN
      // Channel 0 sends a 4-beat packet while channel 1 keeps requesting
      begin
         int  beats;
         bit  hs;
         beats = 0;
         s_tvalid = 4'b0011; s_tlast = 4'b0010;
         while (beats < 4) begin
            s_tdata[0 +: DW] = {$urandom, $urandom};
            s_tdata[DW +: DW] = {$urandom, $urandom};
            s_tlast[0] = (beats == 3);
            @(negedge clk); #2;
            hs = s_tready[0];
            step();
            if (hs) beats++;
         end
         s_tvalid = '0;
         repeat (25) step();
      end
`endif

      // Reset while three samples are in flight: they must be dropped silently
      s_tvalid = 4'b0001;
      repeat (3) begin rand_beats(); step(); end
      s_tvalid = '0;
      repeat (5) step();
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_cordic_tvalid", c_tvalid, 0);
      check("async_rst_m_tvalid", m_tvalid, 0);
      check("async_rst_err", err, 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (30) step();
      check("post_rst_err", err, 0);
      check("post_rst_m_tvalid", m_tvalid, 0);

      // Spurious CORDIC result with no tag: sticky err, no FIFO write
      inj = 1'b1;
      step();
      inj = 1'b0;
      repeat (5) step();
      check("err_sticky", err, 1);
      check("err_no_write", m_tvalid, 0);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      check("err_cleared", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
